// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: segment/group sizing
// and the per-stage control payload that travels down the pipe.
package cla_pkg;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int n_groups(input int seg, input int block);
    return seg / block;
  endfunction

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Operands and partial sums have stage-dependent widths, so only the
  // fixed-width control part is a shared type.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group: sum, carry-out and the
// group propagate/generate terms for use by the enclosing carry chain.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             c_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             c_o,
  output logic             p_o,
  output logic             g_o
);

  logic [BLOCK-1:0] g, p, gg, pp;
  logic [BLOCK:0]   c;

  assign g = a_i & b_i;
  assign p = a_i | b_i;

  // Prefix G/P over bits [i:0] so each carry sees c_i through a single AND-OR.
  always_comb begin
    gg    = '0;
    pp    = '0;
    c     = '0;
    gg[0] = g[0];
    pp[0] = p[0];
    for (int i = 1; i < BLOCK; i++) begin
      gg[i] = g[i] | (p[i] & gg[i-1]);
      pp[i] = p[i] & pp[i-1];
    end
    c[0] = c_i;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = gg[i] | (pp[i] & c_i);
    end
  end

  assign sum_o = a_i ^ b_i ^ c[BLOCK-1:0];
  assign c_o   = c[BLOCK];
  assign p_o   = pp[BLOCK-1];
  assign g_o   = gg[BLOCK-1];

endmodule

// File: rtl/cla_adder_pipelined.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES segment per
// stage, registered carry between stages, lock-step valid/ready advance.
module cla_adder_pipelined
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int NGRP = n_groups(SEG, BLOCK);

  if (WIDTH < 2 || (WIDTH % STAGES) != 0 || (SEG % BLOCK) != 0) begin : g_bad_params
    $error("cla_adder_pipelined: WIDTH must split into STAGES segments of whole BLOCK groups");
  end

  logic adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int W_IN = WIDTH - gi * SEG;

    logic [W_IN-1:0]       in_a, in_b;
    stage_ctrl_t           in_ctrl, ctrl_d, ctrl_q;
    logic [SEG-1:0]        seg_sum;
    logic [NGRP:0]         gc;
    logic [NGRP-1:0]       grp_p, grp_g;
    logic [(gi+1)*SEG-1:0] sum_d, sum_q;

    // Subtraction folds into the operands at entry; later stages only add.
    if (gi == 0) begin : g_src
      assign in_a    = i_add1;
      assign in_b    = i_sub ? ~i_add2 : i_add2;
      assign in_ctrl = '{valid: i_valid, carry: i_sub | i_cin};
      assign sum_d   = seg_sum;
    end else begin : g_src
      assign in_a    = g_stage[gi-1].g_hi.a_hi_q;
      assign in_b    = g_stage[gi-1].g_hi.b_hi_q;
      assign in_ctrl = g_stage[gi-1].ctrl_q;
      assign sum_d   = {seg_sum, g_stage[gi-1].sum_q};
    end

    assign gc[0] = in_ctrl.carry;

    for (genvar gj = 0; gj < NGRP; gj++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a_i  (in_a[gj*BLOCK +: BLOCK]),
        .b_i  (in_b[gj*BLOCK +: BLOCK]),
        .c_i  (gc[gj]),
        .sum_o(seg_sum[gj*BLOCK +: BLOCK]),
        .c_o  (gc[gj+1]),
        .p_o  (grp_p[gj]),
        .g_o  (grp_g[gj])
      );

      // Group carry-out must agree with the group's own P/G terms.
      a_grp_carry: assert property (@(posedge i_clk)
        gc[gj+1] == (grp_g[gj] | (grp_p[gj] & gc[gj])));
    end

    assign ctrl_d = '{valid: in_ctrl.valid, carry: gc[NGRP]};

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        ctrl_q <= '0;
        sum_q  <= '0;
      end else if (adv) begin
        ctrl_q <= ctrl_d;
        sum_q  <= sum_d;
      end
    end

    if (gi < STAGES - 1) begin : g_hi
      logic [W_IN-SEG-1:0] a_hi_q, b_hi_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (adv) begin
          a_hi_q <= in_a[W_IN-1:SEG];
          b_hi_q <= in_b[W_IN-1:SEG];
        end
      end
    end else begin : g_out
      logic msb_cin;
      logic ovf_q;

      // Carry into the sign bit, recovered from its sum bit.
      assign msb_cin = seg_sum[SEG-1] ^ in_a[SEG-1] ^ in_b[SEG-1];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= msb_cin ^ gc[NGRP];
        end
      end
    end
  end

  assign adv        = !g_stage[STAGES-1].ctrl_q.valid || i_ready;
  assign o_ready    = adv;
  assign o_valid    = g_stage[STAGES-1].ctrl_q.valid;
  assign o_result   = {g_stage[STAGES-1].ctrl_q.carry, g_stage[STAGES-1].sum_q};
  assign o_overflow = g_stage[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_cla_adder_pipelined.sv
// Self-checking bench: directed corner beats, back-pressure streams and a
// reset-in-flight case, all checked against an arithmetic reference model.
module tb_cla_adder_pipelined;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int BLOCK  = 4;

  typedef logic [WIDTH+1:0] exp_t;  // {overflow, carry, sum}

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in, ready_out, valid_out, ready_in;
  logic [WIDTH-1:0] add1, add2;
  logic             cin, sub;
  logic [WIDTH:0]   result;
  logic             ovf;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  cla_adder_pipelined #(.WIDTH(WIDTH), .STAGES(STAGES), .BLOCK(BLOCK)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid_in),
    .o_ready   (ready_out),
    .i_add1    (add1),
    .i_add2    (add2),
    .i_cin     (cin),
    .i_sub     (sub),
    .o_valid   (valid_out),
    .i_ready   (ready_in),
    .o_result  (result),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned result modulo 2^(WIDTH+1) and signed range test.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
    logic [WIDTH:0] r, two_w;
    longint         sa, sb, sr, smax, smin;
    logic           ov;
    two_w          = '0;
    two_w[WIDTH]   = 1'b1;
    sa             = longint'($signed(a));
    sb             = longint'($signed(b));
    smax           = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin           = -(longint'(1) <<< (WIDTH - 1));
    if (s) begin
      r  = {1'b0, a} + two_w - {1'b0, b};
      sr = sa - sb;
    end else begin
      r  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      sr = sa + sb + longint'(c);
    end
    ov = (sr > smax) || (sr < smin);
    return {ov, r};
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    logic [WIDTH-1:0] m;
    m = '0;
    case ($urandom_range(0, 7))
      0: m = '0;
      1: m = '1;
      2: m[WIDTH-1] = 1'b1;
      3: begin m = '1; m[WIDTH-1] = 1'b0; end
      default: m = WIDTH'($urandom);
    endcase
    return m;
  endfunction

  task automatic rand_beat();
    add1 = pick();
    add2 = pick();
    cin  = 1'($urandom_range(0, 1));
    sub  = 1'($urandom_range(0, 1));
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s);
    exp_t exp;
    int   lat;
    exp = model(a, b, c, s);
    @(posedge clk); #1;
    ready_in = 1'b1;
    valid_in = 1'b1;
    add1 = a; add2 = b; cin = c; sub = s;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, STAGES - 1);
    chk({tag, "_result"}, result, exp[WIDTH:0]);
    chk({tag, "_ovf"}, ovf, exp[WIDTH+1]);
    $display("%s: a=%h b=%h cin=%0b sub=%0b -> result=%h ovf=%0b", tag, a, b, c, s, result, ovf);
  endtask

  // Streams n beats; rnd=0 uses ready pattern 1,0,0,1 and no idle inputs.
  task automatic stream(input int n, input bit rnd);
    int         sent, got, cyc, dcyc, limit;
    bit         acc, held;
    logic [3:0] pat;
    logic [WIDTH:0] held_res;
    logic       held_ovf;
    exp_t       exp;
    sent = 0; got = 0; cyc = 0; dcyc = 0; held = 1'b0;
    limit = n * 30 + 200;
    pat = 4'b1001;
    held_res = '0;
    held_ovf = 1'b0;
    @(posedge clk); #1;
    ready_in = rnd ? ($urandom_range(0, 2) != 0) : pat[0];
    fork
      begin
        if (rnd && $urandom_range(0, 3) == 0) valid_in = 1'b0;
        else begin valid_in = 1'b1; rand_beat(); end
        while (sent < n && dcyc < limit) begin
          @(negedge clk);
          acc = valid_in && ready_out;
          @(posedge clk); #1;
          dcyc++;
          if (acc) begin
            exp_q.push_back(model(add1, add2, cin, sub));
            sent++;
          end
          if (acc || !valid_in) begin
            if (sent < n && !(rnd && $urandom_range(0, 3) == 0)) begin
              valid_in = 1'b1;
              rand_beat();
            end else begin
              valid_in = 1'b0;
            end
          end
        end
        valid_in = 1'b0;
      end
      begin
        while (got < n && cyc < limit) begin
          @(negedge clk);
          cyc++;
          chk("ready_rule", ready_out, !valid_out || ready_in);
          if (held) begin
            chk("hold_valid", valid_out, 1'b1);
            chk("hold_result", result, held_res);
            chk("hold_ovf", ovf, held_ovf);
          end
          if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
              chk("spurious_output", 1'b1, 1'b0);
            end else begin
              exp = exp_q.pop_front();
              chk("stream_result", result, exp[WIDTH:0]);
              chk("stream_ovf", ovf, exp[WIDTH+1]);
            end
            $display("beat %0d: result=%h ovf=%0b", got, result, ovf);
            got++;
            held = 1'b0;
          end else if (valid_out) begin
            held     = 1'b1;
            held_res = result;
            held_ovf = ovf;
          end else begin
            held = 1'b0;
          end
          @(posedge clk); #1;
          ready_in = rnd ? ($urandom_range(0, 2) != 0) : pat[cyc % 4];
        end
        chk("stream_count", got, n);
      end
    join
    ready_in = 1'b1;
    chk("stream_leftover", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    add1 = '0; add2 = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ready", ready_out, 1'b1);

    directed("one_plus_one", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    directed("carry_chain",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    directed("pos_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    directed("sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    directed("sub_overflow", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);

    stream(10, 1'b0);

    // Reset while three beats are in flight.
    @(posedge clk); #1;
    ready_in = 1'b1;
    valid_in = 1'b1;
    repeat (3) begin
      rand_beat();
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", valid_out, 1'b0);
    chk("midrst_ready", ready_out, 1'b1);
    seen = 1'b0;
    repeat (STAGES + 4) begin
      @(posedge clk); #1;
      if (valid_out) seen = 1'b1;
    end
    chk("midrst_no_ghost", seen, 1'b0);
    directed("after_reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

    stream(400, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
